// File: rtl/scan_pkg.sv
// scan_pkg: shared state encoding, widths and helpers for the digit scan controller
package scan_pkg;
    localparam int NUM_DIGITS = 4;
    localparam int DIGIT_W = 2;
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] BLANK = 2'd1;
    localparam logic [1:0] SHOW  = 2'd2;
    function automatic int max3(input int a, input int b, input int c);
        return a > b ? (a > c ? a : c) : (b > c ? b : c);
    endfunction
endpackage

// File: rtl/next_digit_sel.sv
// next_digit_sel: rotating priority finder for the next enabled digit index
module next_digit_sel
    import scan_pkg::*;
(
    input  logic [DIGIT_W-1:0]    cur,
    input  logic [NUM_DIGITS-1:0] mask,
    input  logic                  from_zero,
    output logic [DIGIT_W-1:0]    next,
    output logic                  none
);
    logic [DIGIT_W-1:0] start;
    assign start = from_zero ? '0 : cur + DIGIT_W'(1);
    assign none  = ~|mask;
    // Scan from the farthest offset down so the nearest enabled index wins
    always_comb begin
        next = cur;
        for (int k = NUM_DIGITS - 1; k >= 0; k--)
            if (mask[start + DIGIT_W'(k)]) next = start + DIGIT_W'(k);
    end
endmodule

// File: rtl/digit_scan_ctrl.sv
// digit_scan_ctrl: multiplexed 7-segment digit scan sequencer with blanking dead-time
// Optional brightness dimming is enabled by defining SCAN_DIM_EN.
module digit_scan_ctrl
    import scan_pkg::*;
#(
    parameter int PRESCALE     = 1024,
    parameter int BLANK_CYCLES = 16,
    parameter int NUM_DIGITS   = scan_pkg::NUM_DIGITS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [NUM_DIGITS-1:0] digit_en,
`ifdef SCAN_DIM_EN
    input  logic [2:0]            brightness,
`endif
    output logic [DIGIT_W-1:0]    cntrl,
    output logic                  blank,
    output logic                  slot_start,
    output logic                  busy
);
    localparam int CW = $clog2(max3(PRESCALE, BLANK_CYCLES, 2));
    localparam logic [CW-1:0] LAST_SHOW  = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] LAST_BLANK = CW'(BLANK_CYCLES > 0 ? BLANK_CYCLES - 1 : 0);
    localparam logic [1:0] FIRST = BLANK_CYCLES > 0 ? BLANK : SHOW;

    logic [1:0]         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [DIGIT_W-1:0] cntrl_q, cntrl_d, nxt;
    logic               blank_q, blank_d, slot_start_q, slot_start_d, busy_q, busy_d, none;

    next_digit_sel u_sel (
        .cur       (cntrl_q),
        .mask      (digit_en),
        .from_zero (state_q == IDLE),
        .next      (nxt),
        .none      (none)
    );

    // Sequencing: counter clears on every state entry; digit mask only matters at slot boundaries
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        cntrl_d = cntrl_q;
        if (!enable) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (state_q == IDLE) begin
            cnt_d   = '0;
            state_d = none ? IDLE : FIRST;
            cntrl_d = none ? cntrl_q : nxt;
        end else if (state_q == BLANK && cnt_q == LAST_BLANK) begin
            state_d = SHOW;
            cnt_d   = '0;
        end else if (state_q == SHOW && cnt_q == LAST_SHOW) begin
            cnt_d   = '0;
            state_d = none ? IDLE : FIRST;
            cntrl_d = none ? cntrl_q : nxt;
        end
    end

`ifdef SCAN_DIM_EN
    logic [2:0] bright_q, bright_d;
    // Outputs from next state; brightness latched at SHOW entry trims the lit portion of the slot
    always_comb begin
        slot_start_d = state_d == SHOW && cnt_d == '0;
        bright_d     = slot_start_d ? brightness : bright_q;
        blank_d      = state_d != SHOW || 32'(cnt_d) >= (32'(bright_d) + 32'd1) * 32'(PRESCALE / 8);
        busy_d       = state_d != IDLE;
    end
    // Brightness register for the current slot
    always_ff @(posedge clk)
        bright_q <= reset ? 3'd0 : bright_d;
`else
    // Outputs derived from next state so they are registered alongside it
    always_comb begin
        slot_start_d = state_d == SHOW && cnt_d == '0;
        blank_d      = state_d != SHOW;
        busy_d       = state_d != IDLE;
    end
`endif

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            cntrl_q      <= '0;
            blank_q      <= 1'b1;
            slot_start_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            cntrl_q      <= cntrl_d;
            blank_q      <= blank_d;
            slot_start_q <= slot_start_d;
            busy_q       <= busy_d;
        end
    end

    assign cntrl      = cntrl_q;
    assign blank      = blank_q;
    assign slot_start = slot_start_q;
    assign busy       = busy_q;
endmodule

// File: tb/tb_digit_scan_ctrl.sv
// tb_digit_scan_ctrl: scoreboard bench for digit_scan_ctrl with and without blanking dead-time
module tb_digit_scan_ctrl;
    logic       clk = 1'b0, reset = 1'b1, enable = 1'b0, en0 = 1'b0;
    logic [3:0] digit_en = 4'hF, mask0 = 4'hF;
    logic [2:0] brightness = 3'd7;
    logic [1:0] cntrl, cntrl0, pc = 2'd0, pc0 = 2'd0;
    logic       blank, slot_start, busy, blank0, slot_start0, busy0;
    logic       pb = 1'b1, pbusy0 = 1'b0;
    int         cyc = 0, errs = 0, checks = 0;
    typedef struct { logic [1:0] d; int c; } exp_t;
    exp_t       q[$], q0[$];
    logic [1:0] seq [7] = '{2'd1, 2'd3, 2'd1, 2'd3, 2'd1, 2'd2, 2'd2};

    digit_scan_ctrl #(.PRESCALE(8), .BLANK_CYCLES(2)) dut (
        .clk(clk), .reset(reset), .enable(enable), .digit_en(digit_en),
`ifdef SCAN_DIM_EN
        .brightness(brightness),
`endif
        .cntrl(cntrl), .blank(blank), .slot_start(slot_start), .busy(busy));

    digit_scan_ctrl #(.PRESCALE(8), .BLANK_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .enable(en0), .digit_en(mask0),
`ifdef SCAN_DIM_EN
        .brightness(brightness),
`endif
        .cntrl(cntrl0), .blank(blank0), .slot_start(slot_start0), .busy(busy0));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (slot_start) begin
            if (q.size() == 0) chk("slot without expectation", 1, 0);
            else begin
                e = q.pop_front();
                chk("slot cntrl", cntrl, e.d);
                chk("slot cycle", cyc, e.c);
                chk("slot blank", blank, 0);
            end
        end
        if (!pb && !blank) chk("cntrl stable in show", cntrl, pc);
        pc <= cntrl;
        pb <= blank;
    end

    always @(negedge clk) begin
        exp_t e;
        if (slot_start0) begin
            if (q0.size() == 0) chk("nb slot without expectation", 1, 0);
            else begin
                e = q0.pop_front();
                chk("nb slot cntrl", cntrl0, e.d);
                chk("nb slot cycle", cyc, e.c);
            end
        end
        if (busy0) chk("nb blank while running", blank0, 0);
        if (busy0 && pbusy0 && cntrl0 != pc0) chk("nb cntrl change off slot", slot_start0, 1);
        pc0    <= cntrl0;
        pbusy0 <= busy0;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int e0, f0, g0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst cntrl", cntrl, 0);
        chk("rst blank", blank, 1);
        chk("rst slot_start", slot_start, 0);
        chk("rst busy", busy, 0);
        chk("nb rst cntrl", cntrl0, 0);
        chk("nb rst blank", blank0, 1);
        chk("nb rst slot_start", slot_start0, 0);
        chk("nb rst busy", busy0, 0);

        e0 = cyc;
        enable = 1'b1;
        for (int i = 0; i < 3; i++) q.push_back('{d: 2'(i), c: e0 + 3 + 10 * i});
        wait_until(e0 + 1);
        chk("start blank", blank, 1);
        chk("start busy", busy, 1);
        wait_until(e0 + 25);
        enable = 1'b0;
        wait_until(e0 + 26);
        chk("disable blank", blank, 1);
        chk("disable busy", busy, 0);
        chk("disable cntrl held", cntrl, 2);
        chk("disable slot_start", slot_start, 0);

        f0 = cyc;
        digit_en = 4'b1010;
        enable = 1'b1;
        for (int i = 0; i < 7; i++) q.push_back('{d: seq[i], c: f0 + 3 + 10 * i});
        wait_until(f0 + 45);
        digit_en = 4'b0100;
        wait_until(f0 + 50);
        chk("disabled slot completes blank", blank, 0);
        chk("disabled slot completes cntrl", cntrl, 1);
        wait_until(f0 + 51);
        chk("boundary blank", blank, 1);
        chk("boundary cntrl", cntrl, 2);
        wait_until(f0 + 61);
        chk("single digit blank", blank, 1);
        chk("single digit cntrl", cntrl, 2);

        wait_until(f0 + 71);
        chk("in blank before reset", blank, 1);
        reset = 1'b1;
        digit_en = 4'b0000;
        wait_until(f0 + 72);
        reset = 1'b0;
        chk("mid rst cntrl", cntrl, 0);
        chk("mid rst blank", blank, 1);
        chk("mid rst slot_start", slot_start, 0);
        chk("mid rst busy", busy, 0);
        wait_until(f0 + 92);
        chk("empty mask busy", busy, 0);
        chk("empty mask blank", blank, 1);

        g0 = cyc;
        en0 = 1'b1;
        for (int i = 0; i < 4; i++) q0.push_back('{d: 2'(i), c: g0 + 1 + 8 * i});
        wait_until(g0 + 27);
        en0 = 1'b0;
        wait_until(g0 + 28);
        chk("nb disable busy", busy0, 0);
        chk("nb disable blank", blank0, 1);
        chk("nb disable cntrl held", cntrl0, 3);
        wait_until(g0 + 30);
        chk("pending slots", q.size(), 0);
        chk("nb pending slots", q0.size(), 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
